mc_controller: RTL and testbench

- Multicycle main-control FSM inside the `mips` core.
- Sits directly upstream of the datapath and unified memory interface: it drives `iord`, `irwrite` and `memwrite` toward memory, plus all datapath mux and enable controls.
- Decodes the opcode of the latched instruction and sequences FETCH/DECODE/execute/writeback states.
- Also produces the PC enable and an instructions-retired counter.

---
 rtl/mc_controller.sv | 182 ++++++++++++++++++
 tb/tb_mc_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle main-control FSM for the mips core.
// Sequences FETCH/DECODE/execute/writeback, drives memory and datapath
// controls, the PC enable and an instructions-retired counter.
// Optional feature: define MC_CTRL_ORI_EN to add ori (ORIEX/ORIWB, aluop=11).
module mc_controller #(
    parameter int INSTR_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic                   zero,
    output logic                   iord,
    output logic                   memwrite,
    output logic                   irwrite,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   memtoreg,
    output logic                   alusrca,
    output logic [1:0]             alusrcb,
    output logic [1:0]             aluop,
    output logic [1:0]             pcsrc,
    output logic                   pcen,
    output logic                   illegal,
    output logic [INSTR_CNT_W-1:0] instret,
    output logic [3:0]             state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        ORIEX   = 4'd12,
        ORIWB   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_ORI_EN
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    state_t state_q, state_d;
    logic   pcwrite, branch, retire;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore control decode; everything defaults to 0.
    always_comb begin
        state_d  = FETCH;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        illegal  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_CTRL_ORI_EN
                    OP_ORI:       state_d = ORIEX;
`endif
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
            end
`ifdef MC_CTRL_ORI_EN
            // The datapath zero-extends the immediate onto signimm for ori.
            ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
                state_d = ORIWB;
            end
            ORIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
`endif
            // Unused encodings recover to FETCH with all controls low.
            default: state_d = FETCH;
        endcase
    end

    // Retired-instruction counter; reset wins over increment, wraps freely.
    always_ff @(posedge clk) begin
        if (reset)       instret <= '0;
        else if (retire) instret <= instret + 1'b1;
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus pushes per-cycle expected
// state/controls/instret; a negedge monitor pops and compares.
module tb_mc_controller;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [5:0]   op;
    logic         zero;
    logic         iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0]   alusrcb, aluop, pcsrc;
    logic         pcen, illegal;
    logic [W-1:0] instret;
    logic [3:0]   state;

    mc_controller #(.INSTR_CNT_W(W)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .pcen(pcen), .illegal(illegal), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    // ctl = {iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,aluop,pcsrc,pcen,illegal}
    localparam logic [14:0] C_FETCH  = {7'b0010000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [14:0] C_DECODE = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_DECILL = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [14:0] C_MEMADR = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_MEMRD  = {7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_MEMWB  = {7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_MEMWR  = {7'b1100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_RTYPE  = {7'b0000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_ALUWB  = {7'b0001100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_BEQ1   = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [14:0] C_BEQ0   = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0};
    localparam logic [14:0] C_ADDIEX = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_ADDIWB = {7'b0001000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_JEX    = {7'b0000000, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0};
`ifdef MC_CTRL_ORI_EN
    localparam logic [14:0] C_ORIEX  = {7'b0000001, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] C_ORIWB  = {7'b0001000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
`endif

    typedef struct {
        logic [3:0]   st;
        logic [14:0]  ctl;
        logic [W-1:0] cnt;
        string        nm;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] cnt = '0;
    logic [14:0]  act_ctl;

    assign act_ctl = {iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                      alusrcb, aluop, pcsrc, pcen, illegal};

    task automatic push(input logic [3:0] st, input logic [14:0] ctl, input string nm);
        exp_t e;
        e.st = st; e.ctl = ctl; e.cnt = cnt; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one expected record per cycle while the scoreboard holds any.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks += 3;
                if (state !== e.st) begin
                    failures++;
                    $display("FAIL %s state: got %0d want %0d", e.nm, state, e.st);
                end
                if (act_ctl !== e.ctl) begin
                    failures++;
                    $display("FAIL %s ctl: got %b want %b", e.nm, act_ctl, e.ctl);
                end
                if (instret !== e.cnt) begin
                    failures++;
                    $display("FAIL %s instret: got %0d want %0d", e.nm, instret, e.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1; op = 6'b100011; zero = 1'b0;
        @(posedge clk); #1;
        push(4'd0, C_FETCH, "reset");
        cycles(1);
        reset = 1'b0;

        // lw
        push(4'd0, C_FETCH, "lw"); push(4'd1, C_DECODE, "lw"); push(4'd2, C_MEMADR, "lw");
        push(4'd3, C_MEMRD, "lw"); push(4'd4, C_MEMWB, "lw");
        cycles(5); cnt++;

        // sw
        op = 6'b101011;
        push(4'd0, C_FETCH, "sw"); push(4'd1, C_DECODE, "sw"); push(4'd2, C_MEMADR, "sw");
        push(4'd5, C_MEMWR, "sw");
        cycles(4); cnt++;

        // beq taken / not taken
        op = 6'b000100; zero = 1'b1;
        push(4'd0, C_FETCH, "beq_t"); push(4'd1, C_DECODE, "beq_t"); push(4'd8, C_BEQ1, "beq_t");
        cycles(3); cnt++;
        zero = 1'b0;
        push(4'd0, C_FETCH, "beq_n"); push(4'd1, C_DECODE, "beq_n"); push(4'd8, C_BEQ0, "beq_n");
        cycles(3); cnt++;

        // R-type, addi, j back to back
        op = 6'b000000;
        push(4'd0, C_FETCH, "rtype"); push(4'd1, C_DECODE, "rtype"); push(4'd6, C_RTYPE, "rtype");
        push(4'd7, C_ALUWB, "rtype");
        cycles(4); cnt++;
        op = 6'b001000;
        push(4'd0, C_FETCH, "addi"); push(4'd1, C_DECODE, "addi"); push(4'd9, C_ADDIEX, "addi");
        push(4'd10, C_ADDIWB, "addi");
        cycles(4); cnt++;
        op = 6'b000010;
        push(4'd0, C_FETCH, "j"); push(4'd1, C_DECODE, "j"); push(4'd11, C_JEX, "j");
        cycles(3); cnt++;

        // illegal opcode: not counted
        op = 6'b111111;
        push(4'd0, C_FETCH, "ill"); push(4'd1, C_DECILL, "ill");
        cycles(2);

        // ori
        op = 6'b001101;
`ifdef MC_CTRL_ORI_EN
        push(4'd0, C_FETCH, "ori"); push(4'd1, C_DECODE, "ori"); push(4'd12, C_ORIEX, "ori");
        push(4'd13, C_ORIWB, "ori");
        cycles(4); cnt++;
`else
        push(4'd0, C_FETCH, "ori_ill"); push(4'd1, C_DECILL, "ori_ill");
        cycles(2);
`endif

        // reset while in MEMRD: abandons lw, clears count, no regwrite next
        op = 6'b100011;
        push(4'd0, C_FETCH, "lw_rst"); push(4'd1, C_DECODE, "lw_rst"); push(4'd2, C_MEMADR, "lw_rst");
        push(4'd3, C_MEMRD, "lw_rst");
        cycles(3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cnt = '0;

        // 16 j instructions wrap the 4-bit counter back to 0
        op = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            push(4'd0, C_FETCH, "jwrap"); push(4'd1, C_DECODE, "jwrap"); push(4'd11, C_JEX, "jwrap");
            cycles(3); cnt++;
        end
        push(4'd0, C_FETCH, "wrapped");
        cycles(1);

        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            cycles(1);
            guard++;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
